// File: rtl/des_stream_engine_if.sv
// One AXI-Stream channel. The engine takes its input block stream on a slave
// instance and drives its result stream on a master instance.
interface des_stream_engine_if #(
  parameter int DATA_W = 64
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/des_stream_engine.sv
// AXI-Stream front end for the iterative DES round core: issues one round per
// cycle, applies ECB/CBC chaining and buffers results in a small output FIFO.
module des_stream_engine #(
  parameter int DATA_W     = 64,
  parameter int NUM_ROUNDS = 16,
  parameter int ROUND_W    = 4,
  parameter int CORE_LAT   = 1,
  parameter int OUT_DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rst,
  des_stream_engine_if.slave  s_axis,
  des_stream_engine_if.master m_axis,
  input  logic                cfg_decrypt,
  input  logic                cfg_cbc,
  input  logic [DATA_W-1:0]   iv,
  input  logic                iv_load,
  output logic [DATA_W-1:0]   core_din,
  output logic [ROUND_W-1:0]  core_round,
  output logic                core_decrypt,
  input  logic [DATA_W-1:0]   core_dout,
  output logic                busy,
  output logic [31:0]         blk_count
);
  localparam int PTR_W     = $clog2(OUT_DEPTH);
  localparam int CNT_W     = $clog2(OUT_DEPTH) + 1;
  localparam int LAT_W     = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
  localparam int WAIT_LAST = (CORE_LAT > 1) ? CORE_LAT - 2 : 0;
  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, WAIT, CAPT} state_t;

  state_t              state, state_nxt;
  logic [LAT_W-1:0]    wait_ctr;
  logic                mode_cbc;
  logic [DATA_W-1:0]   chain, chain_cur, ct_save, res;
  logic                ready, accept, capt;

  logic [DATA_W-1:0]   mem [OUT_DEPTH];
  logic [PTR_W-1:0]    wptr, rptr;
  logic [CNT_W-1:0]    mem_count, fifo_count;
  logic [DATA_W-1:0]   out_data;
  logic                out_valid, pop, load_out;

  assign fifo_count = mem_count + CNT_W'(out_valid);
  assign ready      = !rst && (state == IDLE) && (fifo_count < CNT_W'(OUT_DEPTH));
  assign busy       = (state != IDLE);

  // An iv_load coinciding with acceptance must already chain this block.
  assign chain_cur = iv_load ? iv : chain;
  assign res       = (mode_cbc && core_decrypt) ? (core_dout ^ chain) : core_dout;

  assign s_axis.tready = ready;
  assign m_axis.tdata  = out_data;
  assign m_axis.tvalid = out_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capt      = 1'b0;
    unique case (state)
      IDLE: if (s_axis.tvalid && ready) begin
        accept    = 1'b1;
        state_nxt = RUN;
      end
      RUN:  if (core_round == LAST_ROUND) state_nxt = (CORE_LAT > 1) ? WAIT : CAPT;
      WAIT: if (wait_ctr == LAT_W'(WAIT_LAST)) state_nxt = CAPT;
      CAPT: begin
        capt      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_din     <= '0;
      core_round   <= '0;
      core_decrypt <= 1'b0;
      mode_cbc     <= 1'b0;
      wait_ctr     <= '0;
      chain        <= '0;
      blk_count    <= '0;
    end else begin
      if (accept) begin
        core_decrypt <= cfg_decrypt;
        mode_cbc     <= cfg_cbc;
        core_din     <= (cfg_cbc && !cfg_decrypt) ? (s_axis.tdata ^ chain_cur) : s_axis.tdata;
        core_round   <= '0;
      end else if (state == RUN && core_round != LAST_ROUND) begin
        core_round <= core_round + ROUND_W'(1);
      end

      if (state == WAIT) wait_ctr <= wait_ctr + LAT_W'(1);
      else               wait_ctr <= '0;

      if (state == IDLE && iv_load)  chain <= iv;
      else if (capt && mode_cbc)     chain <= core_decrypt ? ct_save : res;

      if (capt) blk_count <= blk_count + 32'd1;
    end
  end

  // Output FIFO: storage ring feeding a registered head; a new entry becomes
  // visible one cycle after it is written.
  assign pop      = out_valid && m_axis.tready;
  assign load_out = (mem_count != '0) && (!out_valid || pop);

  always_ff @(posedge clk) begin
    if (accept) ct_save   <= s_axis.tdata;
    if (capt)   mem[wptr] <= res;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      mem_count <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (capt) wptr <= wptr + PTR_W'(1);
      if (load_out) begin
        rptr      <= rptr + PTR_W'(1);
        out_data  <= mem[rptr];
        out_valid <= 1'b1;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
      mem_count <= mem_count + CNT_W'(capt) - CNT_W'(load_out);
    end
  end
endmodule

// File: tb/tb_des_stream_engine.sv
// Bench for des_stream_engine: a Feistel stand-in for the round core, a queue
// based reference model of chaining/FIFO/counters, plus directed scenarios.
module tb_des_stream_engine;
  localparam logic [63:0] P0 = 64'h4E6F772069732074;
  localparam logic [63:0] P1 = 64'h68652074696D6520;
  localparam logic [63:0] IV = 64'h1234567890ABCDEF;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  des_stream_engine_if #(.DATA_W(64)) s_axis ();
  des_stream_engine_if #(.DATA_W(64)) m_axis ();

  logic        cfg_decrypt = 1'b0, cfg_cbc = 1'b0, iv_load = 1'b0;
  logic [63:0] iv = '0;
  logic [63:0] core_din, core_dout;
  logic [3:0]  core_round;
  logic        core_decrypt, busy;
  logic [31:0] blk_count;

  des_stream_engine dut (
    .clk(clk), .rst(rst), .s_axis(s_axis), .m_axis(m_axis),
    .cfg_decrypt(cfg_decrypt), .cfg_cbc(cfg_cbc), .iv(iv), .iv_load(iv_load),
    .core_din(core_din), .core_round(core_round), .core_decrypt(core_decrypt),
    .core_dout(core_dout), .busy(busy), .blk_count(blk_count)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Toy cipher: 16-round Feistel, one round per core clock, halves swapped at output.
  function automatic logic [31:0] subkey(input int i);
    return (32'h9E3779B9 * (i + 1)) ^ 32'h0F1E2D3C;
  endfunction

  function automatic logic [31:0] ffn(input logic [31:0] r, input logic [31:0] k);
    logic [31:0] t;
    t = r + k;
    return t ^ {t[20:0], t[31:21]} ^ (t >> 7);
  endfunction

  function automatic logic [63:0] cipher(input logic [63:0] x, input logic dec);
    logic [31:0] l, r, t;
    l = x[63:32];
    r = x[31:0];
    for (int i = 0; i < 16; i++) begin
      t = r;
      r = l ^ ffn(r, subkey(dec ? 15 - i : i));
      l = t;
    end
    return {r, l};
  endfunction

  logic [63:0] cstate = '0;
  always @(posedge clk) begin
    if (core_round == 4'd0)
      cstate <= {core_din[31:0], core_din[63:32] ^
                 ffn(core_din[31:0], subkey(core_decrypt ? 15 : 0))};
    else
      cstate <= {cstate[31:0], cstate[63:32] ^
                 ffn(cstate[31:0], subkey(core_decrypt ? 15 - int'(core_round) : int'(core_round)))};
  end
  assign core_dout = {cstate[31:0], cstate[63:32]};

  // Reference model, stepped once per cycle on the falling edge.
  logic [63:0] exp_q[$];
  logic [63:0] out_log[$];
  int          pend_q[$];
  logic [63:0] chain_m = '0;
  int          cyc = 0, blk_model = 0, accepts = 0;

  initial forever begin
    logic [63:0] x, r;
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
      pend_q.delete();
      chain_m   = '0;
      blk_model = 0;
    end else begin
      while (pend_q.size() > 0 && pend_q[0] == cyc) begin
        void'(pend_q.pop_front());
        blk_model++;
      end
      chk("blk_count", 64'(blk_count), 64'(blk_model));
      if (m_axis.tvalid && m_axis.tready) begin
        out_log.push_back(m_axis.tdata);
        if (exp_q.size() == 0) chk("m_axis_unexpected_beat", m_axis.tdata, ~m_axis.tdata);
        else                   chk("m_axis_tdata", m_axis.tdata, exp_q.pop_front());
      end
      if (!busy && iv_load) chain_m = iv;
      if (s_axis.tvalid && s_axis.tready) begin
        x = s_axis.tdata;
        if (!cfg_cbc) r = cipher(x, cfg_decrypt);
        else if (!cfg_decrypt) begin
          r = cipher(x ^ chain_m, 1'b0);
          chain_m = r;
        end else begin
          r = cipher(x, 1'b1) ^ chain_m;
          chain_m = x;
        end
        exp_q.push_back(r);
        pend_q.push_back(cyc + 18);
        accepts++;
      end
    end
    cyc++;
  end

  logic rand_mode = 1'b0;
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_mode) begin
      m_axis.tready = ($urandom_range(0, 3) != 0);
      iv_load       = ($urandom_range(0, 5) == 0);
      iv            = {$urandom, $urandom};
    end
  end

  task automatic send(input logic [63:0] d, input logic dec, input logic cbc,
                      input logic ivl, input logic [63:0] ivv);
    bit ok;
    ok = 0;
    s_axis.tdata  = d;
    s_axis.tvalid = 1'b1;
    cfg_decrypt   = dec;
    cfg_cbc       = cbc;
    if (ivl) begin
      iv      = ivv;
      iv_load = 1'b1;
    end
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (s_axis.tready) ok = 1;
      @(posedge clk);
      #1;
    end
    s_axis.tvalid = 1'b0;
    if (ivl) iv_load = 1'b0;
    s_axis.tdata = {$urandom, $urandom};
    cfg_decrypt  = 1'($urandom_range(0, 1));
    cfg_cbc      = 1'($urandom_range(0, 1));
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_outs(input int n);
    int k;
    for (k = 0; k < 400 && out_log.size() < n; k++) @(posedge clk);
    #1;
    if (out_log.size() < n) chk("output_timeout", 64'(out_log.size()), 64'(n));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_s_tready"}, 64'(s_axis.tready), 64'd0);
    chk({tag, "_m_tvalid"}, 64'(m_axis.tvalid), 64'd0);
    chk({tag, "_m_tdata"}, m_axis.tdata, 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_blk_count"}, 64'(blk_count), 64'd0);
    chk({tag, "_core_din"}, core_din, 64'd0);
    chk({tag, "_core_round"}, 64'(core_round), 64'd0);
    chk({tag, "_core_decrypt"}, 64'(core_decrypt), 64'd0);
  endtask

  initial begin
    int          lat, a0;
    bit          dec_ok, found;
    logic [63:0] c_ecb, c0, c1;
    logic [63:0] blks [6];
    s_axis.tdata  = '0;
    s_axis.tvalid = 1'b0;
    m_axis.tready = 1'b1;
    #1 rst = 1'b1;
    #1 check_reset("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("model_roundtrip", cipher(cipher(P0, 1'b0), 1'b1), P0);

    // ECB encrypt, latency from acceptance to first valid output
    out_log.delete();
    send(P0, 1'b0, 1'b0, 1'b0, '0);
    chk("core_din_ecb", core_din, P0);
    lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (m_axis.tvalid) lat = k;
    end
    chk("latency", 64'(lat), 64'd18);
    wait_outs(1);
    c_ecb = out_log[0];

    // ECB decrypt with the direction held for the whole block
    send(c_ecb, 1'b1, 1'b0, 1'b0, '0);
    dec_ok = 1;
    for (int k = 0; k < 40 && busy; k++) begin
      if (!core_decrypt) dec_ok = 0;
      @(posedge clk);
      #1;
    end
    chk("core_decrypt_held", 64'(dec_ok), 64'd1);
    wait_outs(2);
    chk("ecb_dec_plain", out_log[1], P0);

    // CBC encrypt, iv loaded together with the first block
    out_log.delete();
    send(P0, 1'b0, 1'b1, 1'b1, IV);
    send(P1, 1'b0, 1'b1, 1'b0, '0);
    wait_outs(2);
    c0 = out_log[0];
    c1 = out_log[1];

    // CBC decrypt: iv loaded while idle, a second load while busy is ignored
    out_log.delete();
    iv = IV;
    iv_load = 1'b1;
    @(posedge clk);
    #1 iv_load = 1'b0;
    send(c0, 1'b1, 1'b1, 1'b0, '0);
    @(posedge clk);
    #1 iv = 64'hDEADBEEFCAFEF00D;
    iv_load = 1'b1;
    @(posedge clk);
    #1 iv_load = 1'b0;
    send(c1, 1'b1, 1'b1, 1'b0, '0);
    wait_outs(2);
    chk("cbc_dec_plain0", out_log[0], P0);
    chk("cbc_dec_plain1", out_log[1], P1);

    // Backpressure: only OUT_DEPTH blocks fit while downstream stalls
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    out_log.delete();
    m_axis.tready = 1'b0;
    a0 = accepts;
    for (int i = 0; i < 6; i++) blks[i] = {$urandom, $urandom};
    for (int i = 0; i < 4; i++) send(blks[i], 1'b0, 1'b0, 1'b0, '0);
    s_axis.tdata  = blks[4];
    s_axis.tvalid = 1'b1;
    cfg_decrypt   = 1'b0;
    cfg_cbc       = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    chk("full_tready", 64'(s_axis.tready), 64'd0);
    chk("full_accepts", 64'(accepts - a0), 64'd4);
    chk("full_blk_count", 64'(blk_count), 64'd4);
    m_axis.tready = 1'b1;
    send(blks[4], 1'b0, 1'b0, 1'b0, '0);
    send(blks[5], 1'b0, 1'b0, 1'b0, '0);
    wait_outs(6);
    chk("drain_blk_count", 64'(blk_count), 64'd6);

    // Reset in the middle of a block
    send(P0, 1'b0, 1'b0, 1'b0, '0);
    found = 0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(posedge clk);
      #1;
      if (core_round == 4'd7) found = 1;
    end
    chk("round7_reached", 64'(found), 64'd1);
    #2 rst = 1'b1;
    #1 check_reset("midrst");
    @(posedge clk);
    #1 rst = 1'b0;
    out_log.delete();
    send(P1, 1'b0, 1'b0, 1'b0, '0);
    wait_outs(1);

    // Randomized traffic with random backpressure and iv loads
    rand_mode = 1'b1;
    for (int i = 0; i < 40; i++)
      send({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, '0);
    rand_mode = 1'b0;
    m_axis.tready = 1'b1;
    iv_load = 1'b0;
    for (int k = 0; k < 400 && (exp_q.size() != 0 || busy); k++) @(posedge clk);
    #1;
    chk("final_drain", 64'(exp_q.size()), 64'd0);
    chk("final_blk_count", 64'(blk_count), 64'(blk_model));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
